// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage integer unit.
// Single-cycle base ALU ops plus iterative (one bit per cycle) RV32M-style
// multiply/divide, behind a valid/ready handshake on both input and output.
// The result register is written only on the edge that enters DONE and is
// held there until the consumer takes it (or kill/reset discards it).
module alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      opcode_alu,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    // Opcode map (base ALU codes are shared with the legacy ALU)
    localparam logic [4:0] OP_ADD    = 5'b00001;
    localparam logic [4:0] OP_SUB    = 5'b00010;
    localparam logic [4:0] OP_XOR    = 5'b00011;
    localparam logic [4:0] OP_OR     = 5'b00100;
    localparam logic [4:0] OP_AND    = 5'b00101;
    localparam logic [4:0] OP_SLL    = 5'b00110;
    localparam logic [4:0] OP_SRL    = 5'b00111;
    localparam logic [4:0] OP_SRA    = 5'b01000;
    localparam logic [4:0] OP_SLT    = 5'b01001;
    localparam logic [4:0] OP_SLTU   = 5'b01010;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    // Most negative signed value; dividing it by -1 is the overflow case
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Control state
    state_t              state_q;
    logic [SHW-1:0]      cnt_q;
    logic [4:0]          op_q;
    logic [XLEN-1:0]     result_q;

    // Original operands, needed for the divide special cases
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;

    // Sign fixups applied after the magnitude iteration
    logic                neg_q;      // product / quotient must be negated
    logic                rneg_q;     // remainder must be negated

    // Shift-add multiplier datapath
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]     mplier_q;

    // Restoring divider datapath
    logic [XLEN-1:0]     rem_q;
    logic [XLEN-1:0]     quo_q;
    logic [XLEN-1:0]     dvs_q;

    // Combinational helpers
    logic                is_mop;
    logic                a_signed;
    logic                b_signed;
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [XLEN-1:0]     alu_res;

    logic [2*XLEN-1:0]   acc_d;
    logic [XLEN:0]       rem_shift;
    logic [XLEN:0]       rem_diff;
    logic [XLEN-1:0]     rem_d;
    logic [XLEN-1:0]     quo_d;

    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix;
    logic [XLEN-1:0]     rem_fix;
    logic                div_zero;
    logic                div_ovf;
    logic [XLEN-1:0]     fin_res;

    // Handshake/status outputs decode straight from the state register
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign result    = result_q;

    // Single-cycle ALU result and operand magnitudes for the M ops
    always_comb begin
        is_mop   = (opcode_alu[4:3] == 2'b10);
        a_signed = (opcode_alu == OP_MULH) || (opcode_alu == OP_MULHSU) ||
                   (opcode_alu == OP_DIV)  || (opcode_alu == OP_REM);
        b_signed = (opcode_alu == OP_MULH) || (opcode_alu == OP_DIV) ||
                   (opcode_alu == OP_REM);
        a_neg    = a_signed & A[XLEN-1];
        b_neg    = b_signed & B[XLEN-1];
        a_mag    = a_neg ? (~A + 1'b1) : A;
        b_mag    = b_neg ? (~B + 1'b1) : B;

        alu_res = '0;
        case (opcode_alu)
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_XOR:  alu_res = A ^ B;
            OP_OR:   alu_res = A | B;
            OP_AND:  alu_res = A & B;
            OP_SLL:  alu_res = A << B[SHW-1:0];
            OP_SRL:  alu_res = A >> B[SHW-1:0];
            OP_SRA:  alu_res = $unsigned($signed(A) >>> B[SHW-1:0]);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (A < B)};
            default: alu_res = '0;
        endcase
    end

    // One multiply step and one restoring-divide step per BUSY cycle
    always_comb begin
        acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        rem_shift = {rem_q, quo_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        // A borrow out of the subtraction means the divisor did not fit
        rem_d     = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
        quo_d     = {quo_q[XLEN-2:0], ~rem_diff[XLEN]};
    end

    // Final result after the last iteration: sign fixup, then special cases
    always_comb begin
        prod_fix = neg_q  ? (~acc_d + 1'b1) : acc_d;
        quo_fix  = neg_q  ? (~quo_d + 1'b1) : quo_d;
        rem_fix  = rneg_q ? (~rem_d + 1'b1) : rem_d;
        div_zero = (b_q == '0);
        div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                   (a_q == SMIN) && (b_q == '1);

        fin_res = '0;
        case (op_q)
            OP_MUL:                         fin_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fin_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (div_zero)      fin_res = '1;
                else if (div_ovf)  fin_res = a_q;
                else               fin_res = quo_fix;
            end
            OP_REM, OP_REMU: begin
                if (div_zero)      fin_res = a_q;
                else if (div_ovf)  fin_res = '0;
                else               fin_res = rem_fix;
            end
            default:                        fin_res = '0;
        endcase
    end

    // Control FSM and datapath registers; kill overrides every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
        end else if (kill) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= opcode_alu;
                        a_q  <= A;
                        b_q  <= B;
                        if (is_mop) begin
                            neg_q    <= a_neg ^ b_neg;
                            rneg_q   <= a_neg;
                            acc_q    <= '0;
                            mcand_q  <= {{XLEN{1'b0}}, a_mag};
                            mplier_q <= b_mag;
                            rem_q    <= '0;
                            quo_q    <= a_mag;
                            dvs_q    <= b_mag;
                            cnt_q    <= '0;
                            state_q  <= S_BUSY;
                        end else begin
                            result_q <= alu_res;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    rem_q    <= rem_d;
                    quo_q    <= quo_d;
                    if (cnt_q == SHW'(XLEN - 1)) begin
                        cnt_q    <= '0;
                        result_q <= fin_res;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: self-checking bench for alu_mdu. A 32-bit and an 8-bit instance
// share one set of stimulus signals; sel8 routes the handshake to one of them.
// Expected values come from a plain-arithmetic reference model.
module tb_alu_mdu;

    localparam logic [4:0] ADD = 5'b00001, SUB = 5'b00010, SLL = 5'b00110;
    localparam logic [4:0] SRL = 5'b00111, SRA = 5'b01000, SLT = 5'b01001;
    localparam logic [4:0] SLTU = 5'b01010, MUL = 5'b10000, MULH = 5'b10001;
    localparam logic [4:0] MULHSU = 5'b10010, MULHU = 5'b10011, DIV = 5'b10100;
    localparam logic [4:0] DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        kill = 1'b0;
    logic        sel8 = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [4:0]  op_in = '0;

    logic        iv32, iv8, or32, or8;
    logic        in_ready32, out_valid32, busy32;
    logic        in_ready8, out_valid8, busy8;
    logic [31:0] result32;
    logic [7:0]  result8;
    logic        in_ready_o, out_valid_o, busy_o;
    logic [31:0] result_o;

    int vectors = 0;
    int errors  = 0;

    assign iv32 = in_valid & ~sel8;
    assign iv8  = in_valid & sel8;
    assign or32 = out_ready & ~sel8;
    assign or8  = out_ready & sel8;
    assign in_ready_o  = sel8 ? in_ready8  : in_ready32;
    assign out_valid_o = sel8 ? out_valid8 : out_valid32;
    assign busy_o      = sel8 ? busy8      : busy32;
    assign result_o    = sel8 ? {24'd0, result8} : result32;

    alu_mdu #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(in_ready32),
        .A(a_in), .B(b_in), .opcode_alu(op_in), .kill(kill),
        .out_valid(out_valid32), .out_ready(or32), .result(result32), .busy(busy32)
    );

    alu_mdu #(.XLEN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(in_ready8),
        .A(a_in[7:0]), .B(b_in[7:0]), .opcode_alu(op_in), .kill(kill),
        .out_valid(out_valid8), .out_ready(or8), .result(result8), .busy(busy8)
    );

    // Reference model: operands interpreted as xl-bit values, 64-bit arithmetic
    function automatic logic [31:0] ref_model(input int xl, input logic [4:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub, p, r;
        longint      sa, sb;
        int          sh;
        bit          ovf;
        mask = (64'd1 << xl) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = ua[xl-1] ? longint'(ua | ~mask) : longint'(ua);
        sb   = ub[xl-1] ? longint'(ub | ~mask) : longint'(ub);
        sh   = int'(ub % 64'(xl));
        ovf  = (sa == -(longint'(1) << (xl - 1))) && (sb == -1);
        p    = '0;
        case (op)
            5'b00001: r = ua + ub;
            5'b00010: r = ua - ub;
            5'b00011: r = ua ^ ub;
            5'b00100: r = ua | ub;
            5'b00101: r = ua & ub;
            5'b00110: r = ua << sh;
            5'b00111: r = ua >> sh;
            5'b01000: r = 64'(sa >>> sh);
            5'b01001: r = (sa < sb) ? 64'd1 : 64'd0;
            5'b01010: r = (ua < ub) ? 64'd1 : 64'd0;
            5'b10000: begin p = ua * ub; r = p; end
            5'b10001: begin p = 64'(sa * sb); r = p >> xl; end
            5'b10010: begin p = 64'(sa) * ub; r = p >> xl; end
            5'b10011: begin p = ua * ub; r = p >> xl; end
            5'b10100: r = (ub == 0) ? mask : (ovf ? ua : 64'(sa / sb));
            5'b10101: r = (ub == 0) ? mask : ua / ub;
            5'b10110: r = (ub == 0) ? ua : (ovf ? 64'd0 : 64'(sa % sb));
            5'b10111: r = (ub == 0) ? ua : ua % ub;
            default:  r = 64'd0;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic int exp_lat(input logic [4:0] op, input int xl);
        return (op[4:3] == 2'b10) ? xl + 1 : 1;
    endfunction

    function automatic int exp_busy(input logic [4:0] op, input int xl);
        return (op[4:3] == 2'b10) ? xl : 0;
    endfunction

    // Drive one full transaction (starting and ending at a negedge) and report
    // what was observed: result, accept-to-out_valid latency, busy cycles and
    // whether the block returned to idle after the output handshake.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] got, output int lat, output int bcnt,
                         output bit rel_ok);
        int guard;
        guard = 0;
        while (in_ready_o !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        op_in = op; a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_in = 5'($urandom); a_in = $urandom; b_in = $urandom;
        lat = 1;
        bcnt = 0;
        while (out_valid_o !== 1'b1 && lat < 200) begin
            if (busy_o === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        got = result_o;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        rel_ok = (out_valid_o === 1'b0) && (in_ready_o === 1'b1);
        $display("xlen=%0d op=%b a=%h b=%h -> result=%h lat=%0d busy=%0d",
                 sel8 ? 8 : 32, op, a, b, got, lat, bcnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({in_ready32, out_valid32, busy32} !== 3'b100 || result32 !== 32'd0) begin
            errors++;
            $display("FAIL reset32: ready/valid/busy=%b result=%h, want 100 result=0",
                     {in_ready32, out_valid32, busy32}, result32);
        end
        vectors++;
        if ({in_ready8, out_valid8, busy8} !== 3'b100 || result8 !== 8'd0) begin
            errors++;
            $display("FAIL reset8: ready/valid/busy=%b result=%h, want 100 result=0",
                     {in_ready8, out_valid8, busy8}, result8);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready32, out_valid32, busy32} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: ready/valid/busy=%b, want 100",
                     {in_ready32, out_valid32, busy32});
        end
    endtask

    task automatic run_table(input string name, input vec_t tab[$]);
        logic [31:0] got;
        int lat, bcnt, xl;
        bit rel;
        xl = sel8 ? 8 : 32;
        foreach (tab[i]) begin
            issue(tab[i].op, tab[i].a, tab[i].b, got, lat, bcnt, rel);
            vectors++;
            if (got !== tab[i].r || lat != exp_lat(tab[i].op, xl) ||
                bcnt != exp_busy(tab[i].op, xl) || !rel) begin
                errors++;
                $display("FAIL %s[%0d] op=%b: got %h lat %0d busy %0d idle %0b, want %h lat %0d busy %0d idle 1",
                         name, i, tab[i].op, got, lat, bcnt, rel, tab[i].r,
                         exp_lat(tab[i].op, xl), exp_busy(tab[i].op, xl));
            end
        end
    endtask

    task automatic test_base();
        vec_t tab[$];
        sel8 = 1'b0;
        tab.push_back('{ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000});
        tab.push_back('{SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF});
        tab.push_back('{SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001});
        tab.push_back('{SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
        tab.push_back('{SRA,  32'h80000000, 32'd31,       32'hFFFFFFFF});
        tab.push_back('{SRL,  32'h80000000, 32'd31,       32'h00000001});
        tab.push_back('{SLL,  32'h00000001, 32'h00000024, 32'h00000010});
        tab.push_back('{5'b11111, 32'h12345678, 32'h1, 32'h00000000});
        run_table("base", tab);
    endtask

    task automatic test_mul();
        vec_t tab[$];
        sel8 = 1'b0;
        tab.push_back('{MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001});
        tab.push_back('{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
        tab.push_back('{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
        tab.push_back('{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
        run_table("mul", tab);
    endtask

    task automatic test_div();
        vec_t tab[$];
        sel8 = 1'b0;
        tab.push_back('{DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD});
        tab.push_back('{REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF});
        tab.push_back('{DIVU, 32'h00000007, 32'h00000000, 32'hFFFFFFFF});
        tab.push_back('{REMU, 32'h00000007, 32'h00000000, 32'h00000007});
        tab.push_back('{DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000});
        tab.push_back('{REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000});
        tab.push_back('{DIV,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF});
        run_table("div", tab);
    endtask

    task automatic test_random(input string name, input int n);
        logic [4:0]  codes[23] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                   5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17,
                                   5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd31};
        logic [31:0] a, b, got, exp, mask, smin;
        int lat, bcnt, xl;
        bit rel;
        logic [4:0] op;
        xl   = sel8 ? 8 : 32;
        mask = (xl == 32) ? 32'hFFFFFFFF : ((32'd1 << xl) - 32'd1);
        smin = 32'd1 << (xl - 1);
        for (int i = 0; i < n; i++) begin
            op = codes[$urandom_range(0, 22)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = smin; b = mask; end
                2: b = 32'($urandom_range(1, 5));
                3: a = a & mask & ~smin;
                default: ;
            endcase
            exp = ref_model(xl, op, a, b);
            issue(op, a, b, got, lat, bcnt, rel);
            vectors++;
            if (got !== exp || lat != exp_lat(op, xl) || bcnt != exp_busy(op, xl) || !rel) begin
                errors++;
                $display("FAIL %s[%0d] op=%b a=%h b=%h: got %h lat %0d busy %0d idle %0b, want %h lat %0d busy %0d idle 1",
                         name, i, op, a, b, got, lat, bcnt, rel, exp,
                         exp_lat(op, xl), exp_busy(op, xl));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, exp;
        int guard;
        sel8 = 1'b0;
        a = $urandom;
        b = $urandom;
        exp = ref_model(32, MUL, a, b);
        op_in = MUL; a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (out_valid_o !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            op_in = ADD; a_in = $urandom; b_in = $urandom;
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (result_o !== exp || in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL hold[%0d]: result %h ready %b valid %b, want %h ready 0 valid 1",
                         i, result_o, in_ready_o, out_valid_o, exp);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL release: ready %b valid %b, want ready 1 valid 0", in_ready_o, out_valid_o);
        end
        op_in = ADD; a_in = 32'd3; b_in = 32'd4; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid_o !== 1'b1 || result_o !== 32'd7) begin
            errors++;
            $display("FAIL next_accept: valid %b result %h, want valid 1 result 00000007",
                     out_valid_o, result_o);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        $display("xlen=32 backpressure MUL a=%h b=%h held result=%h", a, b, exp);
    endtask

    task automatic test_kill();
        bit seen;
        sel8 = 1'b0;
        // Abort in the fifth BUSY cycle of a divide
        op_in = DIV; a_in = 32'd1000; b_in = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        vectors++;
        if ({in_ready_o, busy_o, out_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL kill_busy: ready/busy/valid=%b, want 100", {in_ready_o, busy_o, out_valid_o});
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_o !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            errors++;
            $display("FAIL kill_no_output: out_valid seen 1, want 0");
        end
        // Kill together with out_ready in DONE
        op_in = ADD; a_in = 32'd1; b_in = 32'd2; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        kill = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if ({in_ready_o, out_valid_o} !== 2'b10) begin
            errors++;
            $display("FAIL kill_done: ready/valid=%b, want 10", {in_ready_o, out_valid_o});
        end
        // Kill together with in_valid in IDLE
        op_in = ADD; a_in = 32'd5; b_in = 32'd6; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        kill = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({in_ready_o, busy_o, out_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL kill_idle: ready/busy/valid=%b, want 100", {in_ready_o, busy_o, out_valid_o});
        end
        $display("xlen=32 kill scenarios applied");
    endtask

    task automatic test_async_reset();
        logic [31:0] got;
        int lat, bcnt;
        bit rel, was_busy;
        sel8 = 1'b0;
        issue(ADD, 32'd5, 32'd5, got, lat, bcnt, rel);
        op_in = DIV; a_in = 32'hFFFF0000; b_in = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        was_busy = busy_o;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (!was_busy || {in_ready_o, busy_o, out_valid_o} !== 3'b100 || result_o !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: was_busy %b ready/busy/valid=%b result %h, want 1 100 00000000",
                     was_busy, {in_ready_o, busy_o, out_valid_o}, result_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(SUB, 32'd9, 32'd4, got, lat, bcnt, rel);
        vectors++;
        if (got !== 32'd5 || lat != 1 || !rel) begin
            errors++;
            $display("FAIL after_reset: got %h lat %0d idle %0b, want 00000005 lat 1 idle 1", got, lat, rel);
        end
    endtask

    task automatic test_xlen8();
        vec_t tab[$];
        sel8 = 1'b1;
        @(negedge clk);
        tab.push_back('{MULHU, 32'hFF, 32'hFF, 32'hFE});
        tab.push_back('{DIV,   32'h80, 32'hFF, 32'h80});
        tab.push_back('{REM,   32'h80, 32'hFF, 32'h00});
        tab.push_back('{SRA,   32'h80, 32'h07, 32'hFF});
        run_table("x8", tab);
        test_random("rand8", 20);
        sel8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_base();
        test_mul();
        test_div();
        test_random("rand32", 40);
        test_backpressure();
        test_kill();
        test_async_reset();
        test_xlen8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, handshaked successor of the core's combinational ALU. It executes the base integer ops from the existing 5-bit `opcode_alu` encoding, adds shifts and SLTU, and adds the full RV32M multiply/divide set on an iterative one-bit-per-cycle datapath. It sits in the execute stage. Operands are accepted on a valid/ready handshake, and the registered result is held until the consumer accepts it.

## Interface
- `XLEN`, default 32: operand/result width; power of two, ≥ 8.
- `SHW`, default `$clog2(XLEN)`: shift-amount width; derived, not overridden.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `A`, `B` and `opcode_alu` are valid.
- `in_ready`  out  1: block can accept an operation; equals (state == IDLE).
- `A`  in  XLEN: operand A.
- `B`  in  XLEN: operand B.
- `opcode_alu`  in  5: operation select.
- `kill`  in  1: synchronous abort of any in-flight or held operation.
- `out_valid`  out  1: `result` is valid.
- `out_ready`  in  1: consumer accepts `result`.
- `result`  out  XLEN: registered result.
- `busy`  out  1: high while in BUSY.

## Operation
- Single-cycle ops (result fixed in the accept cycle):
  - ADD 00001, SUB 00010, XOR 00011, OR 00100, AND 00101.
  - SLL 00110, SRL 00111, SRA 01000; all use `B[SHW-1:0]` as the shift amount.
  - SLT 01001 (signed), SLTU 01010 (unsigned); result is 0 or 1, zero-extended.
  - Any other code yields 0 with single-cycle timing.
- Multi-cycle ops:
  - MUL 10000: low XLEN bits of the product.
  - MULH 10001: high bits, signed × signed.
  - MULHSU 10010: high bits, signed A × unsigned B.
  - MULHU 10011: high bits, unsigned × unsigned.
  - DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- Multiply method: sign-handle the operands (take magnitudes, record the result sign), shift-add 1 bit/cycle into a 2·XLEN product, negate at the end if needed.
- Divide method: restoring, 1 bit/cycle, on magnitudes. Remainder takes the dividend's sign; quotient is negative when the operand signs differ.
- Divide special cases, with RISC-V results:
  - Divide by zero: quotient = all-ones; remainder = A.
  - Signed overflow (A = 1<<(XLEN-1), B = −1): quotient = A; remainder = 0.
  - Both cases use normal multi-cycle latency; there is no early exit.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on (in_valid & in_ready), latch the opcode and operands. Go to DONE for a single-cycle op, or BUSY with the iteration counter = 0 for an M op.
  - BUSY: one iteration per cycle. After XLEN iterations, register the final result (sign fixup and special cases) and go to DONE.
  - DONE: `out_valid` = 1 and `result` is stable. On `out_ready`, go to IDLE.
- `kill` takes priority over everything. Any state goes to IDLE next cycle, `out_valid` drops, and the handshake is ignored that cycle.

## Timing
- Reset values: state = IDLE, so `in_ready` = 1. `out_valid` = 0, `busy` = 0, `result` = 0, counter = 0.
- Reset asserted mid-operation clears all state immediately; the in-flight operation is lost.
- Accept edge is cycle 0.
  - Single-cycle op: `out_valid` rises at cycle 1.
  - M op: `busy` is high during cycles 1..XLEN, and `out_valid` rises at cycle XLEN+1.
- `result` changes only on the edge entering DONE; it holds while out_valid & !out_ready.
- Output fires on the edge where (out_valid & out_ready). `in_ready` returns at the next cycle, so minimum issue spacing is 2 cycles for single-cycle ops and XLEN+2 for M ops.
- No accept occurs outside IDLE; `in_valid` in BUSY or DONE is ignored, and the source must hold its request.
- `kill` and `out_ready` in the same DONE cycle: kill wins, and the result counts as not delivered.
- `kill` and `in_valid` in the same IDLE cycle: nothing is accepted.

## Test plan
- Base ops, XLEN=32: ADD 0x7FFFFFFF+1 → 0x80000000; SUB 0−1 → 0xFFFFFFFF; SLT(−1,1) → 1; SLTU(−1,1) → 0; SRA 0x80000000 by 31 → 0xFFFFFFFF; SRL by 31 → 1. Each must have `out_valid` exactly 1 cycle after accept.
- Multiply, XLEN=32: MUL 0xFFFFFFFF×0xFFFFFFFF → 1; MULHU → 0xFFFFFFFE; MULH → 0; MULHSU(−1, 0xFFFFFFFF) → 0xFFFFFFFF. `out_valid` must come 33 cycles after accept, with `busy` high for 32 cycles.
- Divide: DIV −7/2 → −3 with REM −1; DIVU 7/0 → 0xFFFFFFFF with REMU 7; DIV 0x80000000/−1 → 0x80000000 with REM 0.
- Backpressure: hold `out_ready`=0 for 10 cycles after DONE. `result` must stay stable, `in_ready` must stay 0, and `in_valid` pulses must be ignored; on release, the next op is accepted 1 cycle later.
- Abort: `kill` in BUSY cycle 5 gives IDLE next cycle with no `out_valid`; async `rst_n` low mid-divide makes all outputs take their reset values immediately.
- XLEN=8 instance: MULHU 0xFF×0xFF → 0xFE; DIV 0x80/0xFF → 0x80; latency 9 cycles.
